// File: rtl/fifo_stream_packer_pkg.sv
// fifo_stream_packer shared helpers.
// Counter sizing used by the packer and its buffer.
package fifo_stream_packer_pkg;

    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_stream_packer_if.sv
// Valid/ready stream with packet-last marker.
// master drives beats, slave returns ready.
interface fifo_stream_packer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_packer_skid_buf2.sv
// Two-entry in-order buffer between FIFO read data and the stream.
// head_data is always the oldest held entry.
module stream_skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_data <= '0;
            tail_q    <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                    end else begin
                        tail_q <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_data <= tail_q;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new beat joins behind any held one.
                    if (count == 2'd1) begin
                        head_data <= push_data;
                    end else begin
                        head_data <= tail_q;
                        tail_q    <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_packer.sv
// Read-side FIFO consumer: credit-based rd_en, 2-entry buffer,
// fixed-length packet framing and mid-packet starvation timer.
module fifo_stream_packer
    import fifo_stream_packer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PKT_LEN  = 16,
    parameter int IDLE_MAX = 64
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_rd_data,
    output logic                   fifo_rd_en,
    fifo_stream_packer_if.master   m,
    output logic                   pkt_active,
    output logic                   stall_err
);

    localparam int BW = cnt_w(PKT_LEN);
    localparam int IW = cnt_w(IDLE_MAX + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [IW-1:0] IDLE_TOP  = IW'(IDLE_MAX - 1);

    logic [1:0]    count;
    logic [1:0]    occ;
    logic          pending;
    logic          pop;
    logic          last_beat;
    logic          starve;
    logic [BW-1:0] beat_cnt;
    logic [IW-1:0] idle_cnt;

    assign pop = m.m_valid & m.m_ready;

    // Entries held plus the one in flight, after this cycle's pop.
    assign occ = count + {1'b0, pending} - {1'b0, pop};

    assign fifo_rd_en = rd_rst_n & ~fifo_empty & (occ < 2'd2);

    assign m.m_valid = (count != 2'd0);
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign m.m_last  = m.m_valid & last_beat;

    assign starve = pkt_active & ~m.m_valid & ~pending;

    stream_skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (pending),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .count     (count),
        .head_data (m.m_data)
    );

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            pending    <= 1'b0;
            beat_cnt   <= '0;
            pkt_active <= 1'b0;
            idle_cnt   <= '0;
            stall_err  <= 1'b0;
        end else begin
            pending   <= fifo_rd_en;
            stall_err <= 1'b0;

            if (pop) begin
                if (last_beat) begin
                    beat_cnt   <= '0;
                    pkt_active <= 1'b0;
                end else begin
                    beat_cnt   <= beat_cnt + BW'(1);
                    pkt_active <= 1'b1;
                end
            end

            // Backpressure keeps m_valid high, so it never counts as idle.
            if (!starve) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_TOP) begin
                idle_cnt  <= '0;
                stall_err <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Self-checking bench for fifo_stream_packer with a modelled FIFO
// and a scoreboard of expected {last, data} beats.
module tb_fifo_stream_packer;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic       rd_rst_n;
    logic       hold_empty;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = '0;
    logic       pkt_active;
    logic       stall_err;

    logic       fifo_empty1;
    logic       fifo_rd_en1;
    logic [7:0] fifo_rd_data1 = '0;
    logic       pkt_active1;
    logic       stall_err1;

    fifo_stream_packer_if #(.WIDTH(8)) s ();
    fifo_stream_packer_if #(.WIDTH(8)) s1 ();

    int checks = 0;
    int errors = 0;

    logic [7:0] src_mem  [256];
    logic [7:0] src_mem1 [256];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int wr_ptr1 = 0;
    int rd_ptr1 = 0;

    logic [8:0] exp_q  [$];
    logic [8:0] exp1_q [$];

    assign fifo_empty  = (wr_ptr == rd_ptr) || hold_empty;
    assign fifo_empty1 = (wr_ptr1 == rd_ptr1);

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= src_mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
        if (fifo_rd_en1) begin
            fifo_rd_data1 <= src_mem1[rd_ptr1[7:0]];
            rd_ptr1       <= rd_ptr1 + 1;
        end
    end

    fifo_stream_packer #(
        .WIDTH(8), .PKT_LEN(4), .IDLE_MAX(8)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m            (s),
        .pkt_active   (pkt_active),
        .stall_err    (stall_err)
    );

    fifo_stream_packer #(
        .WIDTH(8), .PKT_LEN(1), .IDLE_MAX(8)
    ) dut1 (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty1),
        .fifo_rd_data (fifo_rd_data1),
        .fifo_rd_en   (fifo_rd_en1),
        .m            (s1),
        .pkt_active   (pkt_active1),
        .stall_err    (stall_err1)
    );

    task automatic cyc();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_src(input logic [7:0] d, input logic last);
        src_mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back({last, d});
    endtask

    task automatic push_src1(input logic [7:0] d);
        src_mem1[wr_ptr1[7:0]] = d;
        wr_ptr1 = wr_ptr1 + 1;
        exp1_q.push_back({1'b1, d});
    endtask

    task automatic apply_reset(input int n);
        rd_rst_n = 1'b0;
        repeat (n) cyc();
        rd_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        hold_empty = 1'b0;
        s.m_ready  = 1'b1;
        rd_rst_n   = 1'b0;
        push_src(8'hA5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            checks++;
            if (fifo_rd_en !== 1'b0 || s.m_valid !== 1'b0 ||
                s.m_last !== 1'b0 || stall_err !== 1'b0 ||
                pkt_active !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c=%0d: rd_en=%b valid=%b last=%b stall=%b act=%b, required all 0",
                         c, fifo_rd_en, s.m_valid, s.m_last, stall_err, pkt_active);
            end
        end
        rd_rst_n = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: rd_en=%b, required 1", fifo_rd_en);
        end
        for (int c = 0; c < 8; c++) begin
            cyc();
            #1;
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL reset_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL reset_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: %0d beats left, required 0", exp_q.size());
        end
    endtask

    task automatic test_stream();
        logic [8:0] e;
        logic       ev;
        hold_empty = 1'b1;
        s.m_ready  = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 8; i++) push_src(8'(16 + i), (i % 4) == 3);
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (c == 0) hold_empty = 1'b0;
            #1;
            if (c == 0) begin
                checks++;
                if (fifo_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_rd_en: got %b, required 1", fifo_rd_en);
                end
            end
            ev = (c >= 2 && c <= 9);
            checks++;
            if (s.m_valid !== ev) begin
                errors++;
                $display("FAIL stream_valid c=%0d: got %b, required %b", c, s.m_valid, ev);
            end
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL stream_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || pkt_active !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: left=%0d act=%b, required 0 and 0", exp_q.size(), pkt_active);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        logic [7:0] held = '0;
        hold_empty = 1'b1;
        s.m_ready  = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 12; i++) push_src(8'(32 + i), (i % 4) == 3);
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (c == 0) hold_empty = 1'b0;
            s.m_ready = !(c >= 5 && c < 10);
            #1;
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL bp_rd_when_empty c=%0d: rd_en=1, required 0", c);
            end
            if (c == 5) held = s.m_data;
            if (c >= 5 && c < 10) begin
                checks++;
                if (fifo_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_rd_en c=%0d: got %b, required 0", c, fifo_rd_en);
                end
            end
            if (c >= 6 && c < 10) begin
                checks++;
                if (s.m_valid !== 1'b1 || s.m_data !== held) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d: valid=%b data=%h, required 1 and %h",
                             c, s.m_valid, s.m_data, held);
                end
            end
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL bp_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d beats left, required 0", exp_q.size());
        end
    endtask

    task automatic test_starvation();
        logic [8:0] e;
        logic       es;
        hold_empty = 1'b1;
        s.m_ready  = 1'b1;
        apply_reset(2);
        push_src(8'h30, 1'b0);
        push_src(8'h31, 1'b0);
        for (int c = 0; c < 26; c++) begin
            cyc();
            if (c == 0) hold_empty = 1'b0;
            #1;
            es = (c == 12) || (c == 20);
            checks++;
            if (stall_err !== es) begin
                errors++;
                $display("FAIL starve_pulse c=%0d: got %b, required %b", c, stall_err, es);
            end
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL starve_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL starve_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || pkt_active !== 1'b1) begin
            errors++;
            $display("FAIL starve_end: left=%0d act=%b, required 0 and 1", exp_q.size(), pkt_active);
        end
    endtask

    task automatic test_no_stall();
        logic [8:0] e;
        hold_empty = 1'b1;
        s.m_ready  = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 4; i++) push_src(8'(64 + i), i == 3);
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (c == 0) hold_empty = 1'b0;
            #1;
            checks++;
            if (stall_err !== 1'b0) begin
                errors++;
                $display("FAIL nostall_pulse c=%0d: got %b, required 0", c, stall_err);
            end
            if (s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL nostall_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL nostall_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || pkt_active !== 1'b0) begin
            errors++;
            $display("FAIL nostall_end: left=%0d act=%b, required 0 and 0", exp_q.size(), pkt_active);
        end
    endtask

    task automatic test_pkt_len1();
        logic [8:0] e;
        logic       ev;
        hold_empty = 1'b1;
        s1.m_ready = 1'b1;
        apply_reset(2);
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c == 0) begin
                for (int i = 0; i < 6; i++) push_src1(8'(80 + i));
            end
            #1;
            ev = (c >= 2 && c <= 7);
            checks++;
            if (s1.m_valid !== ev || pkt_active1 !== 1'b0 || stall_err1 !== 1'b0) begin
                errors++;
                $display("FAIL len1_flags c=%0d: valid=%b act=%b stall=%b, required %b 0 0",
                         c, s1.m_valid, pkt_active1, stall_err1, ev);
            end
            if (s1.m_valid && s1.m_ready) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL len1_extra: got %h, required no beat", s1.m_data);
                end else begin
                    e = exp1_q.pop_front();
                    if ({s1.m_last, s1.m_data} !== e) begin
                        errors++;
                        $display("FAIL len1_beat: got %h, required %h", {s1.m_last, s1.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp1_q.size() != 0) begin
            errors++;
            $display("FAIL len1_drain: %0d beats left, required 0", exp1_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] e;
        hold_empty = 1'b1;
        s.m_ready  = 1'b1;
        apply_reset(2);
        for (int i = 0; i < 8; i++) push_src(8'(96 + i), (i % 4) == 3);
        for (int c = 0; c < 18; c++) begin
            cyc();
            if (c == 0) hold_empty = 1'b0;
            if (c == 4) rd_rst_n = 1'b0;
            if (c == 5) rd_rst_n = 1'b1;
            #1;
            if (c == 4) begin
                checks++;
                if (fifo_rd_en !== 1'b0 || exp_q.size() != 6) begin
                    errors++;
                    $display("FAIL midrst_assert: rd_en=%b left=%0d, required 0 and 6",
                             fifo_rd_en, exp_q.size());
                end
                exp_q.delete();
                for (int i = 4; i < 8; i++) exp_q.push_back({i == 7, 8'(96 + i)});
            end
            if (c == 5) begin
                checks++;
                if (s.m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_release: valid=%b rd_en=%b, required 0 and 1",
                             s.m_valid, fifo_rd_en);
                end
            end
            if (rd_rst_n && s.m_valid && s.m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midrst_extra: got %h, required no beat", s.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.m_last, s.m_data} !== e) begin
                        errors++;
                        $display("FAIL midrst_beat: got %h, required %h", {s.m_last, s.m_data}, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || pkt_active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_end: left=%0d act=%b, required 0 and 0", exp_q.size(), pkt_active);
        end
    endtask

    initial begin
        rd_rst_n   = 1'b0;
        hold_empty = 1'b1;
        s.m_ready  = 1'b0;
        s1.m_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_starvation();
        test_no_stall();
        test_pkt_len1();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
